// File: rtl/port_pin_cond.sv
// Pin input conditioning for the GPIO ports: two-stage synchroniser, per-bit
// debounce, per-port maskable pin-change flags and one interrupt request.
module port_pin_cond #(
    parameter int Port_rozm_data = 8,
    parameter int Port_liczba    = 3,
    parameter int DEB_CYKLE      = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [Port_liczba*Port_rozm_data-1:0] pin_raw,
    input  logic [Port_rozm_data-1:0]             dane,
    input  logic [$clog2(Port_liczba)-1:0]        nr_P,
    input  logic                                  wr_PCMSK,
    input  logic                                  wr_PCIFR,
    output logic [Port_liczba*Port_rozm_data-1:0] pin_clean,
    output logic [Port_rozm_data-1:0]             pcifr_out,
    output logic                                  irq
);

    localparam int N  = Port_liczba * Port_rozm_data;
    localparam int W  = Port_rozm_data;
    localparam int CW = $clog2(DEB_CYKLE + 1);
    localparam int SW = $clog2(Port_liczba);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYKLE - 1);

    logic [N-1:0]  sync_p0;
    logic [N-1:0]  sync_p1;
    logic [CW-1:0] cnt [N];
    logic [N-1:0]  chg;
    logic [W-1:0]  pcmsk [Port_liczba];
    logic [W-1:0]  pcifr [Port_liczba];
    logic          pend;

    // True when the CPU port select addresses port p; out-of-range selects
    // match no port, so writes to them vanish and reads return zero.
    function automatic logic port_hit(input int p);
        return nr_P == SW'(p);
    endfunction

    // Stage p0/p1: two-flop synchroniser for the asynchronous raw pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= pin_raw;
            sync_p1 <= sync_p0;
        end
    end

    // A change event fires on the last cycle of an unbroken disagreement run
    always_comb begin
        chg = '0;
        for (int i = 0; i < N; i++)
            chg[i] = (sync_p1[i] != pin_clean[i]) && (cnt[i] == CNT_LAST);
    end

    // Debounce: count consecutive disagreeing cycles, any agreement restarts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pin_clean <= '0;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (sync_p1[i] == pin_clean[i]) begin
                    cnt[i] <= '0;
                end else if (chg[i]) begin
                    pin_clean[i] <= sync_p1[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Mask and flag registers; a set in the same cycle as a clear wins, and a
    // set always sees the mask as it was before any coincident mask write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < Port_liczba; p++) begin
                pcmsk[p] <= '0;
                pcifr[p] <= '0;
            end
        end else begin
            for (int p = 0; p < Port_liczba; p++) begin
                if (wr_PCMSK && port_hit(p))
                    pcmsk[p] <= dane;
                pcifr[p] <= (pcifr[p] & ~((wr_PCIFR && port_hit(p)) ? dane : '0))
                          | (chg[p*W +: W] & pcmsk[p]);
            end
        end
    end

    // Any unmasked pending flag on any port requests an interrupt
    always_comb begin
        pend = 1'b0;
        for (int p = 0; p < Port_liczba; p++)
            pend = pend | (|(pcifr[p] & pcmsk[p]));
    end

    // Registered interrupt request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq <= 1'b0;
        else     irq <= pend;
    end

    // Combinational flag read for the selected port, no side effects
    always_comb begin
        pcifr_out = '0;
        for (int p = 0; p < Port_liczba; p++)
            if (port_hit(p)) pcifr_out = pcifr[p];
    end

endmodule

// File: tb/tb_port_pin_cond.sv
// Randomised bench for port_pin_cond with a sliding-window reference model
// and a handful of directed timing scenarios.
module tb_port_pin_cond;

    localparam int W = 8;
    localparam int P = 3;
    localparam int D = 4;
    localparam int N = P * W;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] pin_raw;
    logic [W-1:0] dane;
    logic [1:0]   nr_P;
    logic         wr_PCMSK;
    logic         wr_PCIFR;
    logic [N-1:0] pin_clean;
    logic [W-1:0] pcifr_out;
    logic         irq;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    logic [N-1:0] hist[$];   // hist[0] = most recent raw sample taken at an edge
    logic [N-1:0] m_clean;
    logic [W-1:0] m_msk [P];
    logic [W-1:0] m_flg [P];
    logic         m_irq;

    always #5 clk = ~clk;

    port_pin_cond #(
        .Port_rozm_data(W),
        .Port_liczba   (P),
        .DEB_CYKLE     (D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pin_raw  (pin_raw),
        .dane     (dane),
        .nr_P     (nr_P),
        .wr_PCMSK (wr_PCMSK),
        .wr_PCIFR (wr_PCIFR),
        .pin_clean(pin_clean),
        .pcifr_out(pcifr_out),
        .irq      (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int j = 0; j < D + 2; j++) hist.push_front('0);
        m_clean = '0;
        for (int p = 0; p < P; p++) begin
            m_msk[p] = '0;
            m_flg[p] = '0;
        end
        m_irq = 1'b0;
    endtask

    // One clock edge of the reference: a clean bit flips once the last D
    // synchronised samples (raw delayed by two edges) all disagree with it.
    task automatic model_step();
        logic [N-1:0] chg;
        logic         nirq;
        logic [W-1:0] clr;
        chg = '0;
        for (int b = 0; b < N; b++) begin
            logic all_diff;
            all_diff = 1'b1;
            for (int j = 1; j <= D; j++)
                if (hist[j][b] == m_clean[b]) all_diff = 1'b0;
            chg[b] = all_diff;
        end
        nirq = 1'b0;
        for (int p = 0; p < P; p++) nirq = nirq | (|(m_flg[p] & m_msk[p]));
        for (int p = 0; p < P; p++) begin
            clr = (wr_PCIFR && int'(nr_P) == p) ? dane : 8'h00;
            m_flg[p] = (m_flg[p] & ~clr) | (chg[p*W +: W] & m_msk[p]);
            if (wr_PCMSK && int'(nr_P) == p) m_msk[p] = dane;
        end
        m_irq = nirq;
        m_clean = m_clean ^ chg;
        hist.push_front(pin_raw);
        void'(hist.pop_back());
    endtask

    function automatic logic [W-1:0] exp_out();
        if (int'(nr_P) < P) return m_flg[nr_P];
        return 8'h00;
    endfunction

    // Advance one edge, update the model, compare just after the edge
    task automatic cycle();
        @(posedge clk);
        if (!rst) model_step();
        #1;
        check("pin_clean", pin_clean, m_clean);
        check("irq", irq, m_irq);
        check("pcifr_out", pcifr_out, exp_out());
    endtask

    task automatic async_reset();
        cycle();
        #3 rst = 1'b1;
        #1;
        check("arst_pin_clean", pin_clean, 0);
        check("arst_irq", irq, 0);
        check("arst_pcifr_out", pcifr_out, 0);
        model_reset();
        repeat (2) cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pin_raw = '0; dane = '0; nr_P = '0;
        wr_PCMSK = 1'b0; wr_PCIFR = 1'b0;
        model_reset();
        repeat (2) cycle();
        check("rst_pin_clean", pin_clean, 0);
        check("rst_irq", irq, 0);
        check("rst_pcifr_out", pcifr_out, 0);
        rst = 1'b0;
        repeat (3) cycle();
        check("post_rst_pin_clean", pin_clean, 0);

        // Clean rise on A0 with PCMSK[0] = 0x01
        nr_P = 2'd0; dane = 8'h01; wr_PCMSK = 1'b1;
        cycle();
        wr_PCMSK = 1'b0;
        pin_raw[0] = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            cycle();
            if (e == 5) check("rise_e5_clean", pin_clean[0], 0);
            if (e == 6) begin
                check("rise_e6_clean", pin_clean[0], 1);
                check("rise_e6_flag", pcifr_out, 8'h01);
                check("rise_e6_irq", irq, 0);
            end
            if (e == 7) check("rise_e7_irq", irq, 1);
        end

        // Clear without event: flag drops now, irq one edge later
        wr_PCIFR = 1'b1; dane = 8'h01;
        cycle();
        wr_PCIFR = 1'b0;
        check("w1c_flag", pcifr_out, 8'h00);
        check("w1c_irq_still", irq, 1);
        cycle();
        check("w1c_irq_drop", irq, 0);

        // Falling edge on A0 with a coincident W1C: set wins
        pin_raw[0] = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            cycle();
            if (e == 5) begin wr_PCIFR = 1'b1; dane = 8'h01; end
            if (e == 6) begin
                wr_PCIFR = 1'b0;
                check("fall_e6_clean", pin_clean[0], 0);
                check("fall_e6_flag_setwins", pcifr_out, 8'h01);
            end
            if (e == 7) check("fall_e7_irq", irq, 1);
        end
        wr_PCIFR = 1'b1; dane = 8'h00;
        cycle();
        check("w1c_zero_nochange", pcifr_out, 8'h01);
        dane = 8'h01;
        cycle();
        wr_PCIFR = 1'b0;
        check("w1c_clear", pcifr_out, 8'h00);
        cycle();
        check("w1c_clear_irq", irq, 0);

        // Glitch on B3: 3 cycles rejected, 4 cycles accepted
        nr_P = 2'd1; dane = 8'h08; wr_PCMSK = 1'b1;
        cycle();
        wr_PCMSK = 1'b0;
        pin_raw[11] = 1'b1;
        repeat (3) cycle();
        pin_raw[11] = 1'b0;
        repeat (8) cycle();
        check("glitch_clean", pin_clean[11], 0);
        check("glitch_flag", pcifr_out, 8'h00);
        check("glitch_irq", irq, 0);
        pin_raw[11] = 1'b1;
        repeat (4) cycle();
        pin_raw[11] = 1'b0;
        repeat (3) cycle();
        check("pulse4_clean", pin_clean[11], 1);
        check("pulse4_flag", pcifr_out, 8'h08);
        repeat (6) cycle();
        wr_PCIFR = 1'b1; dane = 8'hFF;
        cycle();
        wr_PCIFR = 1'b0;
        cycle();

        // Masked C7: level follows, no flag, later unmask raises nothing
        nr_P = 2'd2;
        pin_raw[23] = 1'b1;
        repeat (6) cycle();
        check("masked_clean", pin_clean[23], 1);
        check("masked_flag", pcifr_out, 8'h00);
        check("masked_irq", irq, 0);
        dane = 8'h80; wr_PCMSK = 1'b1;
        cycle();
        wr_PCMSK = 1'b0;
        repeat (2) cycle();
        check("unmask_irq", irq, 0);

        // Out-of-range select: writes ignored, read returns zero
        nr_P = 2'd3; dane = 8'hFF; wr_PCMSK = 1'b1; wr_PCIFR = 1'b1;
        cycle();
        wr_PCMSK = 1'b0; wr_PCIFR = 1'b0;
        check("oor_read", pcifr_out, 8'h00);
        for (int p = 0; p < P; p++) begin
            nr_P = 2'(p);
            cycle();
        end

        // Randomised traffic with occasional async resets mid-debounce
        for (int c = 0; c < 2000; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 7) == 0) pin_raw[b] = ~pin_raw[b];
            nr_P     = 2'($urandom_range(0, 3));
            dane     = 8'($urandom);
            wr_PCMSK = ($urandom_range(0, 7) == 0);
            wr_PCIFR = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 299) == 0) async_reset();
            else cycle();
        end
        wr_PCMSK = 1'b0; wr_PCIFR = 1'b0;
        repeat (2) cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
